// File: rtl/ifu_pkg.sv
// Instruction fetch unit shared types and constants.
package ifu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 2;

    // Instruction presented whenever no fetched word is held (addi x0,x0,0)
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    typedef enum logic [CAUSE_W-1:0] {
        FC_NONE     = 2'b00,
        FC_BUS      = 2'b01,
        FC_MISALIGN = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_e;

endpackage

// File: rtl/ifu_watchdog.sv
// Fetch watchdog: counts consecutive unanswered request cycles and flags
// expiry on the cycle that would reach TIMEOUT_CYC. Built only with IFU_TIMEOUT_EN.
module ifu_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_count,
    input  logic i_clear,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Consecutive wait-cycle counter, cleared on ack or leaving the request state
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = i_count && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word
// until the core consumes it, then advances or redirects the PC. Faults are sticky.
// Optional fetch watchdog enabled by defining IFU_TIMEOUT_EN.
module instr_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic                o_imem_req,
    output logic [XLEN-1:0]     o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [XLEN-1:0]     i_imem_rdata,
    input  logic                i_imem_err,
    output logic [XLEN-1:0]     o_instr,
    output logic [XLEN-1:0]     o_pc,
    output logic                o_instr_vld,
    input  logic                i_instr_rdy,
    input  logic                i_pc_sel,
    input  logic [XLEN-1:0]     i_alu_data,
    output logic                o_fault,
    output logic [CAUSE_W-1:0]  o_fault_cause,
    output logic [XLEN-1:0]     o_retire_cnt
);

    state_e         r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic            r_vld, w_vld_nxt;
    logic            r_req;
    logic            r_fault, w_fault_nxt;
    fault_cause_e    r_cause, w_cause_nxt;
    logic [XLEN-1:0] r_retire, w_retire_nxt;
    logic [XLEN-1:0] w_target;
    logic            w_wd_expire;

    // Redirect target with bit 0 dropped; bit 1 still flags misalignment
    assign w_target = i_alu_data & ~XLEN'(1);

`ifdef IFU_TIMEOUT_EN
    ifu_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_count    ((r_state == S_REQ) && !i_imem_ack),
        .i_clear    ((r_state != S_REQ) || i_imem_ack),
        .o_expire_c (w_wd_expire)
    );
`else
    // No watchdog: requests wait indefinitely and TIMEOUT_CYC has no effect
    assign w_wd_expire = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // Next-state and next-register values
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_vld_nxt    = r_vld;
        w_fault_nxt  = r_fault;
        w_cause_nxt  = r_cause;
        w_retire_nxt = r_retire;
        case (r_state)
            S_REQ: begin
                if (i_imem_ack) begin
                    if (i_imem_err) begin
                        w_state_nxt = S_FAULT;
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = FC_BUS;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_instr_nxt = i_imem_rdata;
                        w_vld_nxt   = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = S_FAULT;
                    w_fault_nxt = 1'b1;
                    w_cause_nxt = FC_TIMEOUT;
                end
            end
            S_HOLD: begin
                if (i_instr_rdy) begin
                    w_retire_nxt = r_retire + XLEN'(1);
                    w_vld_nxt    = 1'b0;
                    w_instr_nxt  = NOP;
                    w_state_nxt  = S_REQ;
                    if (!i_pc_sel) begin
                        w_pc_nxt = r_pc + XLEN'(4);
                    end else if (w_target[1]) begin
                        w_state_nxt = S_FAULT;
                        w_fault_nxt = 1'b1;
                        w_cause_nxt = FC_MISALIGN;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_instr  <= NOP;
            r_vld    <= 1'b0;
            r_req    <= 1'b1;
            r_fault  <= 1'b0;
            r_cause  <= FC_NONE;
            r_retire <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_vld    <= w_vld_nxt;
            r_req    <= (w_state_nxt == S_REQ);
            r_fault  <= w_fault_nxt;
            r_cause  <= w_cause_nxt;
            r_retire <= w_retire_nxt;
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_vld   = r_vld;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_retire_cnt  = r_retire;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level fetch model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;
`ifdef IFU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ack, err, rdy, sel;
    logic [31:0] rdata, alu;
    logic        o_imem_req, o_instr_vld, o_fault;
    logic [31:0] o_imem_addr, o_instr, o_pc, o_retire_cnt;
    logic [1:0]  o_fault_cause;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: does the unit hold an unconsumed word, has it faulted, where is it
    bit          m_have;
    bit          m_faulted;
    logic [1:0]  m_cause;
    logic [31:0] m_pc, m_instr, m_retired;
    int          m_wait;

    instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(15)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .i_imem_err    (err),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_instr_vld   (o_instr_vld),
        .i_instr_rdy   (rdy),
        .i_pc_sel      (sel),
        .i_alu_data    (alu),
        .o_fault       (o_fault),
        .o_fault_cause (o_fault_cause),
        .o_retire_cnt  (o_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic model_step();
        logic [31:0] tgt;
        if (rst) begin
            m_have = 0; m_faulted = 0; m_cause = 2'd0;
            m_pc = RESET_PC; m_instr = NOP_W; m_retired = 0; m_wait = 0;
        end else if (m_faulted) begin
            m_wait = 0;
        end else if (!m_have) begin
            if (ack) begin
                m_wait = 0;
                if (err) begin
                    m_faulted = 1; m_cause = 2'd1;
                end else begin
                    m_have = 1; m_instr = rdata;
                end
            end else begin
                m_wait++;
                if (TO_EN && m_wait >= 15) begin
                    m_faulted = 1; m_cause = 2'd3; m_wait = 0;
                end
            end
        end else if (rdy) begin
            m_retired = m_retired + 1;
            m_have    = 0;
            m_instr   = NOP_W;
            if (sel) begin
                tgt = alu - (alu % 2);
                if (tgt % 4 == 2) begin
                    m_faulted = 1; m_cause = 2'd2;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic compare_all();
        check("req",    {31'd0, o_imem_req},    {31'd0, !m_faulted && !m_have});
        check("addr",   o_imem_addr,            m_pc);
        check("pc",     o_pc,                   m_pc);
        check("vld",    {31'd0, o_instr_vld},   {31'd0, m_have});
        check("instr",  o_instr,                m_have ? m_instr : NOP_W);
        check("fault",  {31'd0, o_fault},       {31'd0, m_faulted});
        check("cause",  {30'd0, o_fault_cause}, {30'd0, m_cause});
        check("retire", o_retire_cnt,           m_retired);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic a, input logic e, input logic [31:0] d,
                         input logic y, input logic s, input logic [31:0] t);
        rst = r; ack = a; err = e; rdata = d; rdy = y; sel = s; alu = t;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    logic [31:0] held;

    initial begin
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();
        check("rst_pc",    o_pc, RESET_PC);
        check("rst_instr", o_instr, NOP_W);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);

        // First fetch: ack on second cycle after reset
        tick();
        drive(0, 1, 0, 32'h0050_0093, 0, 0, 32'h0);
        tick();
        check("first_vld",   {31'd0, o_instr_vld}, 32'd1);
        check("first_instr", o_instr, 32'h0050_0093);
        check("first_pc",    o_pc, 32'h0);

        // Sequential consume, then redirect
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        tick();
        check("seq_addr", o_imem_addr, 32'h4);
        drive(0, 1, 0, 32'h1111_1111, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h0000_0101);
        tick();
        check("redir_addr", o_imem_addr, 32'h0000_0100);

        // Misaligned redirect faults; instruction still retires
        drive(0, 1, 0, 32'h2222_2222, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h0000_0102);
        tick();
        check("mis_cause",  {30'd0, o_fault_cause}, 32'd2);
        check("mis_retire", o_retire_cnt, 32'd3);
        check("mis_pc",     o_pc, 32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, $urandom, 1, 1, $urandom);
            tick();
        end
        check("fault_noreq", {31'd0, o_imem_req}, 32'd0);

        // Bus error
        do_reset();
        drive(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        tick();
        check("bus_cause", {30'd0, o_fault_cause}, 32'd1);

        // Reset coinciding with an ack wins
        drive(1, 1, 0, 32'hCAFE_F00D, 0, 0, 32'h0);
        tick();
        check("rstack_vld",   {31'd0, o_instr_vld}, 32'd0);
        check("rstack_pc",    o_pc, RESET_PC);
        check("rstack_instr", o_instr, NOP_W);

        // No ack for 15 cycles
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("to_fault", {31'd0, o_fault}, {31'd0, TO_EN});
        check("to_cause", {30'd0, o_fault_cause}, TO_EN ? 32'd3 : 32'd0);

        // Long stall with spurious acks, then PC wrap
        do_reset();
        drive(0, 1, 0, 32'h0000_0013, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 1, 0, 32'h1234_5678, 0, 0, 32'h0);
        tick();
        held = o_instr;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, $urandom_range(0, 1), $urandom, 0, $urandom_range(0, 1), $urandom);
            tick();
        end
        check("stall_instr", o_instr, 32'h1234_5678);
        check("stall_same",  o_instr, held);
        check("stall_pc",    o_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        tick();
        check("wrap_addr", o_imem_addr, 32'h0);

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic [31:0] t;
                t = $urandom & 32'h0000_0FFF;
                if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
                drive(0,
                      $urandom_range(0, 9) < 6,
                      $urandom_range(0, 99) < 3,
                      $urandom,
                      $urandom_range(0, 1),
                      $urandom_range(0, 9) < 3,
                      t);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
